// File: rtl/eth_framer.sv
// RMII Ethernet II transmitter: preamble/SFD, fixed header, streamed payload, zero padding,
// CRC32 FCS and a counted inter-frame gap, with cancel/underrun abort handling.
`timescale 1ns/1ps
module eth_framer #(
  parameter logic [47:0] DEST_MAC          = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC           = 48'h6969_5A06_5491,
  parameter logic [15:0] ETHERTYPE         = 16'hABCD,
  parameter int unsigned MAX_PAYLOAD_BYTES = 1500,
  parameter int unsigned IFG_DIBITS        = 48,
  parameter logic [7:0]  PAD_BYTE          = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cancelled,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  input  logic       axiilast,
  output logic       axior,
  output logic       phy_txen,
  output logic [1:0] phy_txd,
  output logic       frame_done,
  output logic       aborted
);

  localparam int unsigned MAX_DIBITS = MAX_PAYLOAD_BYTES * 4;
  localparam int CNT_W = $clog2(MAX_DIBITS + 1);
  localparam int IFG_W = $clog2(IFG_DIBITS + 1);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DIBITS);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(46 * 4);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(31);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(55);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(15);
  // The idle cycle spent in IDLE before PREAMBLE completes the gap, hence the -2.
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_DIBITS - 2);

  localparam logic [111:0] HEADER   = {DEST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [31:0]  CRC_POLY = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_HEADER, S_DATA, S_PAD, S_FCS, S_IFG
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IFG_W-1:0]   ifg_q, ifg_d;
  logic [31:0]        crc_q, crc_d;
  logic               txen_q, txen_d;
  logic [1:0]         txd_q, txd_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;
  logic [6:0]         hdr_lsb;
  logic               byte_end;
  logic               abandon;

  function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign cnt_inc  = cnt_q + 1'b1;
  assign byte_end = (cnt_inc[1:0] == 2'b00);
  // Header bytes go out MSB byte first, each byte low dibit first.
  assign hdr_lsb  = 7'd104 - {cnt_q[5:2], 3'b000} + {4'b0000, cnt_q[1:0], 1'b0};

  assign abandon = (cancelled && (state_q inside {S_PREAMBLE, S_HEADER, S_DATA, S_PAD}))
                 || (cancelled && state_q == S_FCS && cnt_q != FCS_LAST)
                 || (state_q == S_DATA && !axiiv);

  assign axior      = (state_q == S_DATA);
  assign phy_txen   = txen_q;
  assign phy_txd    = txd_q;
  assign frame_done = done_q;
  assign aborted    = abort_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ifg_d   = ifg_q;
    crc_d   = crc_q;
    txen_d  = 1'b0;
    txd_d   = 2'b00;
    done_d  = 1'b0;
    abort_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (axiiv && !cancelled) begin
          state_d = S_PREAMBLE;
          cnt_d   = '0;
          crc_d   = '1;
        end
      end
      S_PREAMBLE: begin
        txen_d = 1'b1;
        txd_d  = (cnt_q == PRE_LAST) ? 2'b11 : 2'b01;
        cnt_d  = cnt_inc;
        if (cnt_q == PRE_LAST) begin
          state_d = S_HEADER;
          cnt_d   = '0;
        end
      end
      S_HEADER: begin
        txen_d = 1'b1;
        txd_d  = HEADER[hdr_lsb +: 2];
        crc_d  = crc_dibit(crc_q, txd_d);
        cnt_d  = cnt_inc;
        if (cnt_q == HDR_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        txen_d = 1'b1;
        txd_d  = axiid;
        crc_d  = crc_dibit(crc_q, txd_d);
        cnt_d  = cnt_inc;
        if (cnt_inc == MAX_CNT || (axiilast && cnt_inc >= MIN_CNT && byte_end)) begin
          state_d = S_FCS;
          cnt_d   = '0;
        end else if (axiilast) begin
          state_d = S_PAD;
        end
      end
      S_PAD: begin
        txen_d = 1'b1;
        txd_d  = PAD_BYTE[{cnt_q[1:0], 1'b0} +: 2];
        crc_d  = crc_dibit(crc_q, txd_d);
        cnt_d  = cnt_inc;
        if (cnt_inc >= MIN_CNT && byte_end) begin
          state_d = S_FCS;
          cnt_d   = '0;
        end
      end
      S_FCS: begin
        txen_d = 1'b1;
        txd_d  = ~crc_q[{cnt_q[3:0], 1'b0} +: 2];
        cnt_d  = cnt_inc;
        if (cnt_q == FCS_LAST) begin
          done_d  = 1'b1;
          state_d = S_IFG;
          ifg_d   = '0;
        end
      end
      S_IFG: begin
        ifg_d = ifg_q + 1'b1;
        if (ifg_q == IFG_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The abort cycle itself drives idle, so the gap counter starts one ahead.
    if (abandon) begin
      state_d = S_IFG;
      ifg_d   = IFG_W'(1);
      cnt_d   = cnt_q;
      crc_d   = crc_q;
      txen_d  = 1'b0;
      txd_d   = 2'b00;
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ifg_q   <= '0;
      crc_q   <= '1;
      txen_q  <= 1'b0;
      txd_q   <= 2'b00;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ifg_q   <= ifg_d;
      crc_q   <= crc_d;
      txen_q  <= txen_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_eth_framer.sv
// Directed bench for eth_framer: captures the RMII stream, rebuilds expected frames and FCS,
// and checks aborts, gaps, padding, payload cap and reset behaviour.
`timescale 1ns/1ps
module tb_eth_framer;

  localparam int MAXB = 50;
  localparam int IFG  = 48;

  logic       clk = 1'b0;
  logic       rst, cancelled, axiiv, axiilast;
  logic [1:0] axiid;
  logic       axior, phy_txen, frame_done, aborted;
  logic [1:0] phy_txd;

  int checks   = 0;
  int failures = 0;

  eth_framer #(.MAX_PAYLOAD_BYTES(MAXB), .IFG_DIBITS(IFG)) dut (
    .clk(clk), .rst(rst), .cancelled(cancelled), .axiiv(axiiv), .axiid(axiid),
    .axiilast(axiilast), .axior(axior), .phy_txen(phy_txen), .phy_txd(phy_txd),
    .frame_done(frame_done), .aborted(aborted)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: captures each txen burst and tracks pulses and gaps.
  logic [1:0] cap[$];
  int  cyc = 0, t_fall = 0, t_abort = -1, last_gap = 0, done_pos = 0;
  int  done_cnt = 0, abort_cnt = 0, abort_wide = 0, axior_bad = 0;
  bit  prev_txen = 1'b0, prev_ab = 1'b0, seen_fall = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (phy_txen) begin
      if (!prev_txen) begin
        if (seen_fall) last_gap = cyc - t_fall;
        cap.delete();
      end
      cap.push_back(phy_txd);
    end else if (prev_txen) begin
      t_fall    = cyc;
      seen_fall = 1'b1;
    end
    if (frame_done) begin
      done_cnt++;
      done_pos = cap.size();
    end
    if (aborted) begin
      abort_cnt++;
      t_abort = cyc;
      if (prev_ab) abort_wide++;
    end
    if (axior && (!phy_txen || cap.size() <= 87)) axior_bad++;
    prev_txen = phy_txen;
    prev_ab   = aborted;
  end

  logic [7:0] pl [0:255];

  function automatic logic [1:0] pl_dib(input int i);
    logic [7:0] b;
    b = pl[i/4];
    return b[2*(i%4) +: 2];
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic do_frame(input int n_dib, input bit use_last, input int drop_at,
                          input int cancel_at, input bit keep_valid, output int acc);
    int  c, seen, idx;
    bit  fin, rdy;
    c = 0; seen = 0; idx = 0; fin = 1'b0;
    while (!fin && c < 3000) begin
      @(negedge clk);
      c++;
      if (phy_txen) seen++;
      if (frame_done || aborted) begin
        fin = 1'b1;
      end else begin
        rdy       = axior;
        axiiv     = (idx != drop_at) && (idx < n_dib);
        axiid     = (idx < n_dib) ? pl_dib(idx) : 2'b00;
        axiilast  = use_last && (idx == n_dib - 1);
        cancelled = (seen == cancel_at);
        if (rdy && axiiv) idx++;
      end
    end
    check("frame_end", fin, 1);
    cancelled = 1'b0;
    axiilast  = 1'b0;
    axiiv     = keep_valid;
    @(negedge clk);
    acc = idx;
  endtask

  task automatic verify_frame(input string tag, input int n_sent);
    logic [7:0]   exp[$];
    logic [111:0] h;
    logic [7:0]   v;
    logic [31:0]  crc, got_fcs, res;
    int           nb, idx, mism;
    h = {48'hFFFF_FFFF_FFFF, 48'h6969_5A06_5491, 16'hABCD};
    for (int k = 0; k < 7; k++) exp.push_back(8'h55);
    exp.push_back(8'hD5);
    for (int k = 0; k < 14; k++) exp.push_back(h[111 - 8*k -: 8]);
    nb = (n_sent + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 4; j++) begin
        idx = 4*b + j;
        v[2*j +: 2] = (idx < n_sent) ? pl_dib(idx) : 2'b00;
      end
      exp.push_back(v);
    end
    for (int b = nb; b < 46; b++) exp.push_back(8'h00);
    crc = 32'hFFFF_FFFF;
    for (int k = 8; k < exp.size(); k++) crc = crc_upd(crc, exp[k]);
    crc = ~crc;
    for (int k = 0; k < 4; k++) exp.push_back(crc[8*k +: 8]);

    check({tag, "_len"}, cap.size(), exp.size() * 4);
    mism = 0;
    for (int j = 0; j < cap.size() && j < exp.size() * 4; j++) begin
      v = exp[j/4];
      if (cap[j] !== v[2*(j%4) +: 2]) mism++;
    end
    check({tag, "_dibit_errors"}, mism, 0);

    got_fcs = '0;
    if (cap.size() >= 16)
      for (int j = 0; j < 16; j++) got_fcs[2*j +: 2] = cap[cap.size() - 16 + j];
    check({tag, "_fcs"}, got_fcs, crc);

    res = 32'hFFFF_FFFF;
    for (int k = 32; k + 3 < cap.size(); k += 4)
      res = crc_upd(res, {cap[k+3], cap[k+2], cap[k+1], cap[k]});
    check({tag, "_residue"}, res, 32'hDEBB_20E3);
    check({tag, "_done_pos"}, done_pos, exp.size() * 4);
  endtask

  initial begin
    int acc, d0, a0, b0, k, hi;
    bit rdy;
    rst = 1'b1; cancelled = 1'b0; axiiv = 1'b0; axiid = 2'b00; axiilast = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txen", phy_txen, 0);
    check("rst_txd", phy_txd, 0);
    check("rst_axior", axior, 0);
    check("rst_done", frame_done, 0);
    check("rst_aborted", aborted, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: exactly 46 bytes, no padding
    for (int i = 0; i < 46; i++) pl[i] = 8'(i);
    d0 = done_cnt; a0 = abort_cnt;
    do_frame(184, 1, -1, -1, 0, acc);
    check("t1_accepted", acc, 184);
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_abort_cnt", abort_cnt - a0, 0);
    verify_frame("t1", 184);

    // 2: single byte, 45 pad bytes
    pl[0] = 8'hA5;
    do_frame(4, 1, -1, -1, 0, acc);
    check("t2_accepted", acc, 4);
    verify_frame("t2", 4);

    // 2b: three dibits, pad completes the partial byte
    pl[0] = 8'hFF;
    do_frame(3, 1, -1, -1, 0, acc);
    check("t2b_accepted", acc, 3);
    verify_frame("t2b", 3);

    // 3: underrun at payload dibit 10
    for (int i = 0; i < 46; i++) pl[i] = 8'(i);
    d0 = done_cnt; a0 = abort_cnt; b0 = abort_wide;
    do_frame(184, 1, 10, -1, 0, acc);
    check("t3_accepted", acc, 10);
    check("t3_txen_dibits", cap.size(), 98);
    check("t3_abort_cnt", abort_cnt - a0, 1);
    check("t3_done_cnt", done_cnt - d0, 0);
    check("t3_abort_at_fall", t_abort, t_fall);
    check("t3_abort_width", abort_wide - b0, 0);
    do_frame(184, 1, -1, -1, 0, acc);
    check("t3_gap", last_gap, IFG);
    verify_frame("t3_next", 184);

    // 4: cancel at header dibit 20
    d0 = done_cnt; a0 = abort_cnt;
    do_frame(184, 1, -1, 52, 0, acc);
    check("t4_txen_dibits", cap.size(), 52);
    check("t4_abort_cnt", abort_cnt - a0, 1);
    check("t4_done_cnt", done_cnt - d0, 0);
    check("t4_abort_at_fall", t_abort, t_fall);
    for (int i = 0; i < 46; i++) pl[i] = 8'(i * 3 + 7);
    do_frame(184, 1, -1, -1, 0, acc);
    check("t4_gap", last_gap, IFG);
    verify_frame("t4_next", 184);

    // 5: back-to-back frames with axiiv held
    b0 = axior_bad;
    do_frame(184, 1, -1, -1, 1, acc);
    verify_frame("t5_a", 184);
    do_frame(184, 1, -1, -1, 0, acc);
    check("t5_gap", last_gap, IFG);
    check("t5_axior_outside_data", axior_bad - b0, 0);
    verify_frame("t5_b", 184);

    // 6: payload cap without axiilast
    for (int i = 0; i < 63; i++) pl[i] = 8'(i * 5 + 1);
    d0 = done_cnt;
    do_frame(252, 0, -1, -1, 0, acc);
    check("t6_accepted", acc, MAXB * 4);
    check("t6_done_cnt", done_cnt - d0, 1);
    verify_frame("t6", MAXB * 4);

    // 6b: reset in the middle of DATA
    repeat (60) @(negedge clk);
    acc = 0; k = 0;
    while (acc < 20 && k < 500) begin
      @(negedge clk);
      k++;
      rdy = axior;
      axiiv = 1'b1; axiid = pl_dib(acc); axiilast = 1'b0;
      if (rdy) acc++;
    end
    check("t6b_reached_data", acc, 20);
    a0 = abort_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6b_txen", phy_txen, 0);
    check("t6b_txd", phy_txd, 0);
    check("t6b_axior", axior, 0);
    check("t6b_done", frame_done, 0);
    check("t6b_aborted", aborted, 0);
    axiiv = 1'b0; rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t6b_no_abort", abort_cnt - a0, 0);

    // 7: cancel held in IDLE blocks the start
    hi = 0;
    axiiv = 1'b1; cancelled = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (phy_txen) hi++;
    end
    axiiv = 1'b0; cancelled = 1'b0;
    check("t7_idle_cancel_txen", hi, 0);

    // Post-reset frame is bit-exact
    for (int i = 0; i < 10; i++) pl[i] = 8'hF0 ^ 8'(i);
    do_frame(40, 1, -1, -1, 0, acc);
    verify_frame("t8", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
